// File: rtl/cpu_bus_pkg.sv
// Shared types and AXI response encodings for the CPU-to-AXI bus bridge.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/cpu_bus_bridge.sv
// Bridges a simple valid/done CPU memory port onto a single-outstanding AXI master,
// with address-window decode and a per-transaction timeout.
module cpu_bus_bridge
    import cpu_bus_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h0100_0000,
    parameter logic [ADDR_W-1:0] ADDR_MASK      = 32'hFFFF_0000,
    parameter int                TIMEOUT_CYCLES = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_valid_i,
    input  logic                mem_wen_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_strb_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_done_o,
    output logic                mem_err_o,
    output logic [ADDR_W-1:0]   m_axi_araddr_o,
    output logic                m_axi_arvalid_o,
    input  logic                m_axi_arready_i,
    input  logic [DATA_W-1:0]   m_axi_rdata_i,
    input  logic [1:0]          m_axi_rresp_i,
    input  logic                m_axi_rvalid_i,
    output logic                m_axi_rready_o,
    output logic [ADDR_W-1:0]   m_axi_awaddr_o,
    output logic                m_axi_awvalid_o,
    input  logic                m_axi_awready_i,
    output logic [DATA_W-1:0]   m_axi_wdata_o,
    output logic [DATA_W/8-1:0] m_axi_wstrb_o,
    output logic                m_axi_wvalid_o,
    input  logic                m_axi_wready_i,
    input  logic [1:0]          m_axi_bresp_i,
    input  logic                m_axi_bvalid_i,
    output logic                m_axi_bready_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return (a & ADDR_MASK) == BASE_ADDR;
    endfunction

    function automatic logic resp_err(input logic [1:0] r);
        return (r == RESP_SLVERR) || (r == RESP_DECERR);
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout;

    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            wen_q     <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            wen_q     <= wen_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        wen_d     = wen_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    strb_d  = mem_strb_i;
                    wen_d   = mem_wen_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (!in_window(mem_addr_i)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (mem_wen_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end

            ST_READ: begin
                cnt_d = cnt_q + 1'b1;
                if (m_axi_arready_i) arvalid_d = 1'b0;
                // A completing beat takes priority over a timeout in the same cycle.
                if (m_axi_rvalid_i && rready_q) begin
                    rdata_d   = m_axi_rdata_i;
                    err_d     = resp_err(m_axi_rresp_i);
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    state_d   = ST_DONE;
                end else if (timeout) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    state_d   = ST_DONE;
                end
            end

            ST_WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (m_axi_awready_i) awvalid_d = 1'b0;
                if (m_axi_wready_i)  wvalid_d  = 1'b0;
                // B is only accepted once both AW and W have left the bridge.
                bready_d = (!awvalid_q || m_axi_awready_i) && (!wvalid_q || m_axi_wready_i);
                if (m_axi_bvalid_i && bready_q) begin
                    err_d     = resp_err(m_axi_bresp_i);
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    state_d   = ST_DONE;
                end else if (timeout) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_done_o      = (state_q == ST_DONE);
    assign mem_err_o       = (state_q == ST_DONE) && err_q;
    assign mem_rdata_o     = rdata_q;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arvalid_o = arvalid_q;
    assign m_axi_rready_o  = rready_q;
    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awvalid_o = awvalid_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = strb_q;
    assign m_axi_wvalid_o  = wvalid_q;
    assign m_axi_bready_o  = bready_q;

endmodule
